vram_rect_fill: RTL

- Hardware rectangle-fill engine on the CPU side of the 320x200 RGB332 framebuffer.
- Turns one command into a burst of single-byte VRAM writes: rectangle origin, size and colour.
- Drives the framebuffer write port (write strobe, 16-bit linear address, 8-bit data) that the video scan-out reads.
- Lets software clear the screen or draw boxes without issuing 64000 individual CPU stores.

---
 rtl/vram_pkg.sv | 17 +
 rtl/vram_rect_fill_if.sv | 28 ++
 rtl/vram_rect_walker.sv | 55 +++++
 rtl/vram_rect_fill.sv | 139 +++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared framebuffer geometry, types and fill FSM states
package vram_pkg;
    localparam int FB_WIDTH_C  = 320;
    localparam int FB_HEIGHT_C = 200;
    localparam int FB_SIZE_C   = 64000;
    localparam int ADDR_W      = 16;

    typedef logic [7:0]        rgb332_t;
    typedef logic [ADDR_W-1:0] vram_addr_t;

    typedef enum logic [1:0] {IDLE, SETUP, FILL, FINISH} fill_state_t;

    // y*320 as two shifts so the default geometry needs no multiplier
    function automatic vram_addr_t row_base_f(input logic [7:0] y);
        return (vram_addr_t'(y) << 8) + (vram_addr_t'(y) << 6);
    endfunction
endpackage

// File: rtl/vram_rect_fill_if.sv
// rtl/vram_rect_fill_if.sv - command/status and framebuffer write port bundle
interface vram_rect_fill_if;
    import vram_pkg::*;

    logic       start;
    logic       abort;
    logic [8:0] rect_x;
    logic [7:0] rect_y;
    logic [8:0] rect_w;
    logic [7:0] rect_h;
    rgb332_t    colour;
    logic       busy;
    logic       done;
    logic       error;
    logic       vram_wr;
    vram_addr_t vram_addr;
    rgb332_t    vram_data;

    modport master (
        output start, abort, rect_x, rect_y, rect_w, rect_h, colour,
        input  busy, done, error, vram_wr, vram_addr, vram_data
    );

    modport slave (
        input  start, abort, rect_x, rect_y, rect_w, rect_h, colour,
        output busy, done, error, vram_wr, vram_addr, vram_data
    );
endinterface

// File: rtl/vram_rect_walker.sv
// rtl/vram_rect_walker.sv - column/row counters and row base accumulator for the fill
module vram_rect_walker
    import vram_pkg::*;
#(
    parameter int FB_WIDTH = FB_WIDTH_C
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       step_i,
    input  logic       abort_i,
    input  logic [8:0] x_i,
    input  logic [8:0] w_i,
    input  logic [7:0] h_i,
    input  vram_addr_t row_base_i,
    output vram_addr_t addr_o,
    output logic       last_o
);
    logic [8:0] col_q, x_q, w_q;
    logic [7:0] row_q, h_q;
    vram_addr_t row_base_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            x_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            row_base_q <= '0;
        end else if (load_i) begin
            col_q      <= '0;
            row_q      <= '0;
            x_q        <= x_i;
            w_q        <= w_i;
            h_q        <= h_i;
            row_base_q <= row_base_i;
        end else if (abort_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (step_i) begin
            // row wrap happens in the same cycle as the last column write
            if (col_q == w_q - 9'd1) begin
                col_q      <= '0;
                row_q      <= row_q + 8'd1;
                row_base_q <= row_base_q + vram_addr_t'(FB_WIDTH);
            end else begin
                col_q <= col_q + 9'd1;
            end
        end
    end

    assign addr_o = row_base_q + vram_addr_t'(x_q) + vram_addr_t'(col_q);
    assign last_o = (col_q == w_q - 9'd1) && (row_q == h_q - 8'd1);
endmodule

// File: rtl/vram_rect_fill.sv
// rtl/vram_rect_fill.sv - rectangle fill engine; VRAM_RECT_FILL_CLIP_EN clips instead of rejecting
module vram_rect_fill
    import vram_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_C,
    parameter int FB_HEIGHT = FB_HEIGHT_C
) (
    input logic             cpu_clk,
    input logic             reset_n,
    vram_rect_fill_if.slave bus
);
    localparam logic [9:0] FB_W10 = 10'(FB_WIDTH);
    localparam logic [8:0] FB_H9  = 9'(FB_HEIGHT);

    fill_state_t state_q;
    logic [8:0]  x_q, w_q;
    logic [7:0]  y_q, h_q;
    rgb332_t     colour_q, data_q;
    logic        busy_q, done_q, error_q, err_q, wr_q;
    vram_addr_t  addr_q;

    logic [9:0]  x_end;
    logic [8:0]  y_end;
    logic [8:0]  w_eff;
    logic [7:0]  h_eff;
    logic        x_oob, y_oob, reject, empty;
    logic        walk_load, walk_step, walk_last;
    vram_addr_t  row_base, walk_addr;

    assign x_end = {1'b0, x_q} + {1'b0, w_q};
    assign y_end = {1'b0, y_q} + {1'b0, h_q};
    assign x_oob = {1'b0, x_q} >= FB_W10;
    assign y_oob = {1'b0, y_q} >= FB_H9;

`ifdef VRAM_RECT_FILL_CLIP_EN
    assign w_eff  = (x_end > FB_W10) ? 9'(FB_W10 - {1'b0, x_q}) : w_q;
    assign h_eff  = (y_end > FB_H9)  ? 8'(FB_H9 - {1'b0, y_q})  : h_q;
    assign reject = 1'b0;
    assign empty  = x_oob || y_oob || (w_eff == 9'd0) || (h_eff == 8'd0);
`else
    assign w_eff  = w_q;
    assign h_eff  = h_q;
    assign reject = x_oob || y_oob || (x_end > FB_W10) || (y_end > FB_H9);
    assign empty  = (w_q == 9'd0) || (h_q == 8'd0);
`endif

    assign row_base  = (FB_WIDTH == 320) ? row_base_f(y_q)
                                         : vram_addr_t'(int'(y_q) * FB_WIDTH);
    assign walk_load = (state_q == SETUP) && !bus.abort && !reject && !empty;
    assign walk_step = (state_q == FILL) && !bus.abort;

    vram_rect_walker #(.FB_WIDTH(FB_WIDTH)) u_walker (
        .clk        (cpu_clk),
        .rst_n      (reset_n),
        .load_i     (walk_load),
        .step_i     (walk_step),
        .abort_i    (bus.abort),
        .x_i        (x_q),
        .w_i        (w_eff),
        .h_i        (h_eff),
        .row_base_i (row_base),
        .addr_o     (walk_addr),
        .last_o     (walk_last)
    );

    // write port is registered, so it trails the FILL state by one cycle
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            colour_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            wr_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        x_q      <= bus.rect_x;
                        y_q      <= bus.rect_y;
                        w_q      <= bus.rect_w;
                        h_q      <= bus.rect_h;
                        colour_q <= bus.colour;
                        busy_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    if (bus.abort) begin
                        err_q   <= 1'b0;
                        state_q <= FINISH;
                    end else if (reject || empty) begin
                        err_q   <= reject;
                        state_q <= FINISH;
                    end else begin
                        err_q   <= 1'b0;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (bus.abort) begin
                        state_q <= FINISH;
                    end else begin
                        wr_q   <= 1'b1;
                        addr_q <= walk_addr;
                        data_q <= colour_q;
                        if (walk_last) begin
                            state_q <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    error_q <= err_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.vram_wr   = wr_q;
    assign bus.vram_addr = addr_q;
    assign bus.vram_data = data_q;
endmodule
